bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Downstream consumer of the BCD counter stages: takes DIGITS packed BCD digits and drives a time-multiplexed common-anode 7-segment display.
- Captures digits into a shadow register on a load strobe, so a counter update cannot tear the display.
- Scans one digit per refresh slot, with a dead-time guard against ghosting.
- Decodes BCD to segments; non-BCD codes show a dash.

Parameters:
- DIGITS, 4, number of display digits (legal range 1..8)
- REFRESH_DIV, 1000, clk cycles per digit slot (must be > DEAD_CYCLES + 1)
- DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off (legal range 0..REFRESH_DIV-2)

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  reset, asynchronous, active-low
- bcd_in  input  4*DIGITS  packed digits; bcd_in[3:0] = digit 0 (rightmost)
- load  input  1  when high at posedge, bcd_in is captured into shadow
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high; a = bit 0
- an  output  DIGITS  anode selects, active-low, one-hot-low or all-high
- slot_start  output  1  one-cycle pulse when a new digit slot begins

Behaviour:
- Reset (rst low, async): div_cnt=0, dig_idx=0, shadow=0, seg=7'h00, an=all ones, slot_start=0.
- div_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0.
  - On that wrap, dig_idx advances by 1, and DIGITS-1 wraps to 0.
- Shadow capture:
  - load=1 replaces all digits at once.
  - load held high captures every cycle.
  - load coinciding with a slot wrap: the new slot already uses the new shadow value in the registered output.
- Outputs are registered with one-cycle latency: seg/an/slot_start at cycle n+1 are functions of div_cnt, dig_idx and shadow at cycle n.
- an:
  - all ones when div_cnt < DEAD_CYCLES.
  - otherwise an[dig_idx]=0 and all other bits 1.
- seg:
  - 7'h00 when div_cnt < DEAD_CYCLES.
  - otherwise the decode of shadow digit dig_idx.
- slot_start=1 exactly when div_cnt==0.
- Decode table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - codes A-F give 40 (segment g only).
- First slot after reset release: digit 0.
  - Dead time runs first: an goes low on the cycle after div_cnt reaches DEAD_CYCLES.
- Reset asserted mid-slot: immediate return to reset values; no partial-slot completion.
- DEAD_CYCLES=0: an is never all-high after the first post-reset cycle.
- DIGITS=1: dig_idx stays 0, and slot_start still pulses every REFRESH_DIV cycles.

Optional Feature:
- Macro: BCD_DISPLAY_SCAN_LZB_EN
- Defined: leading-zero blanking.
  - Any digit i>0 whose value, and the value of every digit above it, is zero in shadow shows seg=7'h00.
  - Its anode is still driven low, so the timing pattern is unchanged.
  - Digit 0 is never blanked.
  - Invalid codes count as nonzero.
- Undefined: all digits always decoded; no blanking logic synthesized.

Test Plan:
1. Reset with DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2:
   - After rst release, an=1111 and seg=00 for the first slot's dead cycles.
   - Then an=1110 and seg=3F (shadow 0).
   - slot_start pulses every 8 cycles.
2. load with bcd_in=16'h1234:
   - Slots show an=1110/seg=66, 1101/4F, 1011/5B, 0111/06.
   - Then wraps back to digit 0.
3. Invalid code, bcd_in=16'h00A9:
   - Digit 1 shows seg=40; digit 0 shows 6F.
   - With LZB_EN: digits 3 and 2 show seg=00 with an still low in their slots.
   - Without LZB_EN: digits 3 and 2 show 3F.
4. load pulsed to 16'h9999 mid-slot (div_cnt=5, digit 1 active):
   - seg changes to 6F one cycle after the load edge.
   - an and div_cnt timing are unaffected.
5. rst pulsed low for 1 cycle mid-slot on digit 2:
   - Outputs drop to seg=00 and an=1111 asynchronously.
   - shadow is cleared to 0.
   - Scanning restarts at digit 0 with full dead time.
6. LZB_EN with shadow=16'h0000:
   - Only digit 0 shows 3F; digits 1-3 show 00.
   - load 16'h0100: digits 0 and 1 show 3F, digit 2 shows 06, digit 3 shows 00.

Source files
------------

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - multiplexed BCD 7-segment scanner; define BCD_DISPLAY_SCAN_LZB_EN for leading-zero blanking
module bcd_display_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  slot_start
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic [4*DIGITS-1:0] shadow;
  logic                slot_wrap;
  logic                in_dead;
  logic [3:0]          cur_digit;
  logic                blank;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h40;
    endcase
  endfunction

  assign slot_wrap = (div_cnt == CNT_LAST);

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (div_cnt < CNT_W'(DEAD_CYCLES));
    end
  endgenerate

  // Slot timer, digit pointer and tear-free shadow copy of the digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      dig_idx <= '0;
      shadow  <= '0;
    end else begin
      if (slot_wrap) begin
        div_cnt <= '0;
        dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      if (load) shadow <= bcd_in;
    end
  end

  // Pick the active digit, decide blanking and build the next anode/segment pattern
  always_comb begin
    cur_digit = 4'd0;
    an_next   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == dig_idx) begin
        cur_digit  = shadow[i*4 +: 4];
        an_next[i] = 1'b0;
      end
    end
`ifdef BCD_DISPLAY_SCAN_LZB_EN
    // A digit is blank when it and every digit above it are zero; digit 0 always shows
    blank = 1'b0;
    begin : lzb_scan
      logic all_zero;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        all_zero = all_zero && (shadow[i*4 +: 4] == 4'd0);
        if ((IDX_W'(i) == dig_idx) && (i != 0)) blank = all_zero;
      end
    end
`else
    blank = 1'b0;
`endif
    if (in_dead) begin
      an_next  = '1;
      seg_next = 7'h00;
    end else if (blank) begin
      seg_next = 7'h00;
    end else begin
      seg_next = bcd_to_seg(cur_digit);
    end
  end

  // Register the display drive so it is glitch-free and one cycle behind the scan state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg        <= 7'h00;
      an         <= '1;
      slot_start <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= an_next;
      slot_start <= (div_cnt == '0);
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - scoreboard bench for bcd_display_scan (DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2)
module tb_bcd_display_scan;

  localparam int DIGITS = 4;
  localparam int RDIV   = 8;
  localparam int DEAD   = 2;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        slot_start;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ss;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp;
  int n_bad;

  int          m_cnt;
  int          m_idx;
  logic [15:0] m_shadow;

  bcd_display_scan #(
    .DIGITS(DIGITS),
    .REFRESH_DIV(RDIV),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bcd_in(bcd_in),
    .load(load),
    .seg(seg),
    .an(an),
    .slot_start(slot_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 4'd9) return 7'h40;
    return tbl[d];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [3:0] d;
    logic blank;
    e.ss  = (m_cnt == 0);
    e.an  = 4'hF;
    e.seg = 7'h00;
    if (m_cnt >= DEAD) begin
      e.an[m_idx] = 1'b0;
      d = m_shadow[m_idx*4 +: 4];
      blank = 1'b0;
`ifdef BCD_DISPLAY_SCAN_LZB_EN
      if (m_idx > 0) begin
        blank = 1'b1;
        for (int j = m_idx; j < DIGITS; j++)
          if (m_shadow[j*4 +: 4] != 4'd0) blank = 1'b0;
      end
`endif
      e.seg = blank ? 7'h00 : seg_of(d);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    m_idx    = 0;
    m_shadow = 16'h0000;
    exp_q.delete();
  endtask

  // Called at a negedge; drives inputs, predicts, waits one posedge, compares, returns at next negedge
  task automatic cycle(input logic ld, input logic [15:0] val);
    exp_t e;
    exp_t got;
    load   = ld;
    bcd_in = val;
    exp_q.push_back(model_out());
    if (ld) m_shadow = val;
    if (m_cnt == RDIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = '{seg: seg, an: an, ss: slot_start};
    check("seg", {9'd0, got.seg}, {9'd0, e.seg});
    check("an", {12'd0, got.an}, {12'd0, e.an});
    check("slot_start", {15'd0, got.ss}, {15'd0, e.ss});
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000);
  endtask

  task automatic run_until(input int idx, input int cnt);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      if (m_idx == idx && m_cnt == cnt) hit = 1'b1;
      else cycle(1'b0, 16'h0000);
    end
    check("reach_slot", {15'd0, hit}, 16'd1);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    load   = 1'b0;
    bcd_in = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg", {9'd0, seg}, 16'h0000);
    check("rst_an", {12'd0, an}, 16'h000F);
    check("rst_slot_start", {15'd0, slot_start}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset release: dead time, then digit 0 showing 0; slot_start every 8
    run(3 * RDIV);

    // 1234 across all four slots and back to digit 0
    cycle(1'b1, 16'h1234);
    run(5 * RDIV);

    // Invalid code plus leading zeros
    cycle(1'b1, 16'h00A9);
    run(4 * RDIV + 2);

    // Mid-slot load on digit 1 at div_cnt 5
    cycle(1'b1, 16'h1234);
    run_until(1, 5);
    cycle(1'b1, 16'h9999);
    cycle(1'b0, 16'h0000);
    check("midload_seg", {9'd0, seg}, 16'h006F);
    run(2 * RDIV);

    // Load held high for several cycles, changing value each cycle
    for (int i = 0; i < 12; i++) cycle(1'b1, 16'($urandom));
    run(4 * RDIV);

    // Async reset mid-slot on digit 2
    cycle(1'b1, 16'h5678);
    run_until(2, 4);
    #2;
    rst = 1'b0;
    #1;
    check("async_seg", {9'd0, seg}, 16'h0000);
    check("async_an", {12'd0, an}, 16'h000F);
    check("async_slot_start", {15'd0, slot_start}, 16'd0);
    model_reset();
    @(negedge clk);
    #0;
    check("held_an", {12'd0, an}, 16'h000F);
    rst = 1'b1;
    run(4 * RDIV + 1);

    // Leading-zero patterns
    cycle(1'b1, 16'h0000);
    run(4 * RDIV);
    cycle(1'b1, 16'h0100);
    run(4 * RDIV + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
